// File: rtl/alu_result_tx.sv
// Serial transmitter for ALU result bytes: a small FIFO feeding an 11-bit frame
// (start, 8 data LSB-first, even parity, stop) on a single registered output pin.
module alu_result_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         res_data,
  input  logic                               res_valid,
  output logic                               res_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned TmrW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            push, pop, bit_end, have_data;

  assign res_ready = count_q < Depth;
  assign push      = res_valid && res_ready;
  assign have_data = count_q != '0;
  assign bit_end   = timer_q == TmrLast;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign level     = count_q;

  // FIFO storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= res_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; pop marks the edge that loads the head into the shifter.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (have_data) begin
          state_d = StStart;
          pop     = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && idx_q == 3'd7) state_d = StParity;
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (have_data) begin
            state_d = StStart;
            pop     = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bit timer, shifter and parity accumulator.
  always_comb begin
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      parity_d = 1'b0;
      timer_d  = '0;
      idx_d    = '0;
    end else if (state_q != StIdle) begin
      timer_d = bit_end ? '0 : timer_q + TmrW'(1);
      if (state_q == StData && bit_end) begin
        parity_d = parity_q ^ shift_q[0];
        shift_d  = {1'b0, shift_q[7:1]};
        idx_d    = idx_q + 3'd1;
      end
    end
  end

  // Outputs are registered, so they are decoded from the next-state values.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = state_d != StIdle;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4); outputs are
// logged at each falling edge and frames are checked against hand-derived bits.
module tb_alu_result_tx;

  logic       clk;
  logic       rst;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic       txlog  [2048];
  logic       bzlog  [2048];
  logic       rdylog [2048];
  logic [2:0] lvlog  [2048];

  alu_result_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log the outputs there.
  task automatic cycle();
    @(negedge clk);
    txlog[cyc]  = tx;
    bzlog[cyc]  = busy;
    rdylog[cyc] = res_ready;
    lvlog[cyc]  = level;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Returns the log index of the first sample after the accepting edge.
  task automatic push(input logic [7:0] b, output int a);
    cycle();
    res_data  = b;
    res_valid = 1'b1;
    cycle();
    res_valid = 1'b0;
    a = cyc - 1;
  endtask

  task automatic check_frame(input int base, input logic [7:0] d, input logic p,
                             input string tag);
    logic [10:0] fr;
    logic [3:0]  s;
    logic        b;
    fr = {1'b1, p, d, 1'b0};
    b  = 1'b1;
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < 4; j++) begin
        s[j] = txlog[base + 4 * k + j];
        b    = b & bzlog[base + 4 * k + j];
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(s), {28'd0, {4{fr[k]}}});
    end
    chk({tag, "_busy"}, 32'(b), 32'd1);
  endtask

  task automatic check_idle(input int i, input string tag);
    chk({tag, "_tx"}, 32'(txlog[i]), 32'd1);
    chk({tag, "_busy"}, 32'(bzlog[i]), 32'd0);
    chk({tag, "_level"}, 32'(lvlog[i]), 32'd0);
  endtask

  initial begin
    int a;
    int base0;
    int nxt;
    int acc [8];

    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = 8'h00;
    run(3);
    check_idle(cyc - 1, "rst");
    chk("rst_ready", 32'(rdylog[cyc - 1]), 32'd1);
    rst = 1'b0;
    run(2);

    // Single byte 0xA5: tx still idle right after accept, start bit one edge later.
    push(8'hA5, a);
    chk("a5_lat_tx", 32'(txlog[a]), 32'd1);
    chk("a5_lat_level", 32'(lvlog[a]), 32'd1);
    run(46);
    check_frame(a + 1, 8'hA5, 1'b0, "a5");
    check_idle(a + 45, "a5_end");

    // Parity: 0x07 has three ones, 0x00 none.
    push(8'h07, a);
    run(46);
    check_frame(a + 1, 8'h07, 1'b1, "p07");
    push(8'h00, a);
    run(46);
    check_frame(a + 1, 8'h00, 1'b0, "p00");
    check_idle(a + 45, "p00_end");

    // Back-to-back: 0x12 (parity 0), 0x34 (parity 1), 0x56 (parity 0).
    cycle();
    res_data  = 8'h12;
    res_valid = 1'b1;
    cycle();
    a = cyc - 1;
    res_data = 8'h34;
    cycle();
    res_data = 8'h56;
    cycle();
    res_valid = 1'b0;
    run(135);
    chk("b2b_lvl0", 32'(lvlog[a]), 32'd1);
    chk("b2b_lvl1", 32'(lvlog[a + 1]), 32'd1);
    chk("b2b_lvl2", 32'(lvlog[a + 2]), 32'd2);
    check_frame(a + 1, 8'h12, 1'b0, "b12");
    chk("b2b_lvl_f2", 32'(lvlog[a + 45]), 32'd1);
    check_frame(a + 45, 8'h34, 1'b1, "b34");
    chk("b2b_lvl_f3", 32'(lvlog[a + 89]), 32'd0);
    check_frame(a + 89, 8'h56, 1'b0, "b56");
    check_idle(a + 133, "b2b_end");

    // Full FIFO: res_valid held high with 0x01..0x06.
    for (int i = 0; i < 8; i++) acc[i] = -1;
    nxt   = 1;
    base0 = cyc;
    for (int c = 0; c < 270; c++) begin
      cycle();
      res_valid = nxt <= 6;
      res_data  = 8'(nxt);
      if (res_valid && rdylog[base0 + c]) begin
        acc[nxt] = c;
        nxt++;
      end
    end
    res_valid = 1'b0;
    chk("full_acc5", 32'(acc[5]), 32'd4);
    chk("full_acc6", 32'(acc[6]), 32'd46);
    chk("full_lvl4", 32'(lvlog[base0 + 5]), 32'd4);
    chk("full_rdy_lo", 32'(rdylog[base0 + 5]), 32'd0);
    chk("full_rdy_lo_last", 32'(rdylog[base0 + 45]), 32'd0);
    chk("full_rdy_hi", 32'(rdylog[base0 + 46]), 32'd1);
    chk("full_lvl3", 32'(lvlog[base0 + 46]), 32'd3);
    check_frame(base0 + 2,       8'h01, 1'b1, "f01");
    check_frame(base0 + 2 + 44,  8'h02, 1'b1, "f02");
    check_frame(base0 + 2 + 88,  8'h03, 1'b0, "f03");
    check_frame(base0 + 2 + 132, 8'h04, 1'b1, "f04");
    check_frame(base0 + 2 + 176, 8'h05, 1'b0, "f05");
    check_frame(base0 + 2 + 220, 8'h06, 1'b0, "f06");
    check_idle(base0 + 266, "full_end");

    // Push coinciding with the STOP->START load edge at level 1.
    cycle();
    res_data  = 8'h81;
    res_valid = 1'b1;
    cycle();
    a = cyc - 1;
    res_data = 8'h43;
    cycle();
    res_valid = 1'b0;
    run(43);
    res_data  = 8'h98;
    res_valid = 1'b1;
    cycle();
    res_valid = 1'b0;
    run(90);
    chk("sim_lvl_before", 32'(lvlog[a + 44]), 32'd1);
    chk("sim_lvl_after", 32'(lvlog[a + 45]), 32'd1);
    check_frame(a + 1,  8'h81, 1'b0, "s81");
    check_frame(a + 45, 8'h43, 1'b1, "s43");
    check_frame(a + 89, 8'h98, 1'b1, "s98");
    check_idle(a + 133, "sim_end");

    // Reset during data bit 3 of 0xFF with two bytes queued.
    cycle();
    res_data  = 8'hFF;
    res_valid = 1'b1;
    cycle();
    a = cyc - 1;
    res_data = 8'h11;
    cycle();
    res_data = 8'h22;
    cycle();
    res_valid = 1'b0;
    run(16);
    chk("mr_pre_tx", 32'(txlog[a + 18]), 32'd1);
    chk("mr_pre_busy", 32'(bzlog[a + 18]), 32'd1);
    chk("mr_pre_level", 32'(lvlog[a + 18]), 32'd2);
    rst = 1'b1;
    #1;
    chk("mr_async_tx", 32'(tx), 32'd1);
    chk("mr_async_busy", 32'(busy), 32'd0);
    chk("mr_async_level", 32'(level), 32'd0);
    chk("mr_async_ready", 32'(res_ready), 32'd1);
    run(2);
    rst = 1'b0;
    run(3);
    check_idle(cyc - 1, "mr_post");
    push(8'h3C, a);
    run(60);
    check_frame(a + 1, 8'h3C, 1'b0, "r3c");
    check_idle(a + 45, "r3c_end");
    check_idle(a + 58, "r3c_nostale");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
